// File: rtl/mips32_pkg.sv
// Shared constants for the MIPS32 pipeline: default register-file geometry,
// write-back latency and operand read-ready point.
package mips32_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW       = $clog2(NUM_REGS_DEF);
  localparam int WB_LAT_DEF   = 3;
  localparam int READY_AT_DEF = 1;
  localparam int R0_IDX       = 0;

endpackage

// File: rtl/reg_wb_countdown.sv
// Per-register write-pending countdown: loads the write-back latency when a
// producer issues, then counts down to zero and holds there.
module reg_wb_countdown #(
  parameter int CW       = 2,
  parameter int LOAD_VAL = 3
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          load,
  output logic [CW-1:0] cnt,
  output logic          busy
);

  localparam logic [CW-1:0] LV = CW'(LOAD_VAL);

  // A new load wins over the decrement so the newest write always sets the wait.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LV;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/mips32_hazard_scoreboard.sv
// Write-pending scoreboard beside the ID stage: stalls an instruction while
// any of its source registers still has a write in flight.
module mips32_hazard_scoreboard
  import mips32_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int WB_LAT   = WB_LAT_DEF,
  parameter int READY_AT = READY_AT_DEF,
  parameter int STAT_W   = 32
) (
  input  logic                        clk1,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs,
  input  logic [$clog2(NUM_REGS)-1:0] id_rt,
  input  logic                        id_uses_rs,
  input  logic                        id_uses_rt,
  input  logic [$clog2(NUM_REGS)-1:0] id_rd,
  input  logic                        id_writes_rd,
  input  logic                        id_kill,
  output logic                        stall,
  output logic                        issue,
  output logic [NUM_REGS-1:0]         busy_map,
  output logic [STAT_W-1:0]           stall_cycles
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(WB_LAT + 1);

  logic [CW-1:0] cnt [NUM_REGS];
  logic          hz_rs;
  logic          hz_rt;
  logic          id_live;

  // R0 is hardwired to zero, so it never has a pending write.
  assign cnt[0]      = '0;
  assign busy_map[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    reg_wb_countdown #(
      .CW       (CW),
      .LOAD_VAL (WB_LAT)
    ) u_cnt (
      .clk1 (clk1),
      .rst  (rst),
      .load (issue & id_writes_rd & (id_rd == AW'(r))),
      .cnt  (cnt[r]),
      .busy (busy_map[r])
    );
  end

  // Hazards look at the counters before this edge's load, so an instruction
  // reading its own destination waits only on the older producer.
  always_comb begin
    hz_rs   = id_uses_rs && (id_rs != AW'(R0_IDX)) && (int'(cnt[id_rs]) > READY_AT);
    hz_rt   = id_uses_rt && (id_rt != AW'(R0_IDX)) && (int'(cnt[id_rt]) > READY_AT);
    id_live = id_valid && !id_kill;
    stall   = id_live && (hz_rs || hz_rt);
    issue   = id_live && !stall;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {STAT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips32_hazard_scoreboard.sv
// Self-checking bench for mips32_hazard_scoreboard: directed pipeline
// sequences plus randomized traffic against a timestamp-based model.
module tb_mips32_hazard_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int WB_LAT   = 3;
  localparam int READY_AT = 1;
  localparam int STAT_W   = 32;

  logic                clk1;
  logic                rst;
  logic                id_valid;
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic [4:0]          id_rd;
  logic                id_writes_rd;
  logic                id_kill;
  logic                stall;
  logic                issue;
  logic [NUM_REGS-1:0] busy_map;
  logic [STAT_W-1:0]   stall_cycles;

  int     checks;
  int     failures;
  int     cyc;
  int     last_wr [NUM_REGS];
  longint stall_exp;
  logic   obs_busy7;

  mips32_hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .WB_LAT   (WB_LAT),
    .READY_AT (READY_AT),
    .STAT_W   (STAT_W)
  ) dut (
    .clk1         (clk1),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_writes_rd (id_writes_rd),
    .id_kill      (id_kill),
    .stall        (stall),
    .issue        (issue),
    .busy_map     (busy_map),
    .stall_cycles (stall_cycles)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: a register written at issue cycle c stays pending for WB_LAT cycles after that edge.
  function automatic int remaining(input int r);
    int rem;
    if (r == 0) return 0;
    rem = last_wr[r] + WB_LAT + 1 - cyc;
    return (rem > 0) ? rem : 0;
  endfunction

  function automatic logic [NUM_REGS-1:0] modelBusy();
    logic [NUM_REGS-1:0] b;
    b = '0;
    for (int r = 1; r < NUM_REGS; r++) b[r] = (remaining(r) > 0);
    return b;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NUM_REGS; r++) last_wr[r] = -1000;
    stall_exp = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] rd,
                               input logic wr, input logic kill,
                               output logic got_issue, output logic got_stall);
    logic hz, e_stall, e_issue;
    @(negedge clk1);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd = rd; id_writes_rd = wr; id_kill = kill;
    #1;
    hz = (urs && rs != 0 && remaining(rs) > READY_AT) || (urt && rt != 0 && remaining(rt) > READY_AT);
    e_stall = v && !kill && hz;
    e_issue = v && !kill && !hz;
    checkOutput("stall", stall, e_stall);
    checkOutput("issue", issue, e_issue);
    checkOutput("busy_map", busy_map, modelBusy());
    checkOutput("stall_cycles", stall_cycles, stall_exp);
    got_issue = issue;
    got_stall = stall;
    obs_busy7 = busy_map[7];
    @(posedge clk1);
    if (e_issue && wr && rd != 0) last_wr[rd] = cyc;
    if (e_stall && stall_exp != 64'hFFFF_FFFF) stall_exp++;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic gi, gs;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, gi, gs);
  endtask

  // Holds one instruction in ID until it issues; returns how many cycles it stalled.
  task automatic issueInsn(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                           input logic urt, input logic [4:0] rd, input logic wr,
                           output int stalls);
    logic gi, gs;
    bit done;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      applyStimulus(1, rs, rt, urs, urt, rd, wr, 0, gi, gs);
      if (gs) stalls++;
      if (gi) done = 1;
    end
    if (!done) checkOutput("issue_timeout", 0, 1);
  endtask

  initial begin
    int s, s1, s2, s3, s4, s5, nbusy;
    logic gi, gs;
    checks = 0; failures = 0; cyc = 0;
    modelReset();
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rd = 0; id_writes_rd = 0; id_kill = 0;
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_issue", issue, 0);
    checkOutput("rst_busy", busy_map, 0);
    checkOutput("rst_stat", stall_cycles, 0);
    @(negedge clk1);
    rst = 1'b0;
    idle(2);

    // ADDI R1,R0,10 ; ADD R4,R1,R2
    issueInsn(0, 0, 1, 0, 1, 1, s1);
    issueInsn(1, 2, 1, 1, 4, 1, s2);
    checkOutput("dep_addi_stalls", s1, 0);
    checkOutput("dep_add_stalls", s2, 2);
    idle(4);
    checkOutput("dep_stat", stall_cycles, 2);

    // ADDI R1; ADDI R2; ADDI R3; ADD R4,R1,R2; ADD R5,R4,R3
    issueInsn(0, 0, 1, 0, 1, 1, s1);
    issueInsn(0, 0, 1, 0, 2, 1, s2);
    issueInsn(0, 0, 1, 0, 3, 1, s3);
    issueInsn(1, 2, 1, 1, 4, 1, s4);
    issueInsn(4, 3, 1, 1, 5, 1, s5);
    checkOutput("seq_stalls_123", s1 + s2 + s3, 0);
    checkOutput("seq_stalls_r4", s4, 1);
    checkOutput("seq_stalls_r5", s5, 2);
    idle(4);
    checkOutput("seq_stat", stall_cycles, 5);

    // R0 as destination and source
    issueInsn(0, 0, 1, 0, 0, 1, s1);
    checkOutput("r0_busy", busy_map[0], 0);
    issueInsn(0, 0, 1, 1, 6, 1, s2);
    checkOutput("r0_stalls", s1 + s2, 0);
    idle(4);

    // WAW + kill on R7: killed rewrite must not extend the pending window
    issueInsn(0, 0, 0, 0, 7, 1, s);
    nbusy = 0;
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, gi, gs);
    nbusy += int'(obs_busy7);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, gi, gs);
      nbusy += int'(obs_busy7);
    end
    checkOutput("waw_kill_busy7", nbusy, 3);

    // Asynchronous reset with counters busy
    issueInsn(0, 0, 1, 0, 1, 1, s);
    issueInsn(1, 0, 1, 0, 2, 1, s);
    @(negedge clk1);
    id_valid = 0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy_map, 0);
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_stat", stall_cycles, 0);
    modelReset();
    @(posedge clk1);
    cyc++;
    @(negedge clk1);
    rst = 1'b0;
    idle(1);

    // Randomized traffic over a small register window to force collisions
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                    ($urandom_range(0, 9) == 0), gi, gs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
